// File: rtl/givens_rotator.sv
// Single-axis Givens rotation of a signed fixed-point 3-vector, using one shared multiplier
// over four product cycles, then round-half-up, saturate and hold under a valid/ready handshake.
module givens_rotator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       axis,
  input  logic [WIDTH-1:0] cos_in,
  input  logic [WIDTH-1:0] sin_in,
  input  logic [WIDTH-1:0] vx,
  input  logic [WIDTH-1:0] vy,
  input  logic [WIDTH-1:0] vz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rx,
  output logic [WIDTH-1:0] ry,
  output logic [WIDTH-1:0] rz,
  output logic             out_sat
);

  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam logic signed [AccW-1:0] RndHalf = AccW'(1) <<< (FRAC - 1);

  typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StRnd, StOut} state_e;

  state_e r_state, w_state_next;

  logic [1:0]              r_axis;
  logic signed [WIDTH-1:0] r_c, r_s, r_vx, r_vy, r_vz;
  logic signed [AccW-1:0]  r_acc_a, r_acc_b;
  logic [WIDTH-1:0]        r_rx, r_ry, r_rz;
  logic                    r_sat;

  logic signed [WIDTH-1:0] w_a, w_b, w_op_x, w_op_y;
  logic signed [AccW-1:0]  w_prod;
  logic [WIDTH:0]          w_res_a, w_res_b;
  logic                    w_accept;

  // Returns {saturated, value}; in range iff all bits above the result MSB equal the sign.
  function automatic logic [WIDTH:0] round_sat(input logic signed [AccW-1:0] acc);
    logic signed [AccW-1:0] sh;
    sh = (acc + RndHalf) >>> FRAC;
    if (sh[AccW-1:WIDTH-1] == '0 || sh[AccW-1:WIDTH-1] == '1) begin
      round_sat = {1'b0, sh[WIDTH-1:0]};
    end else begin
      round_sat = {1'b1, sh[AccW-1], {(WIDTH-1){~sh[AccW-1]}}};
    end
  endfunction

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StOut);
  assign w_accept  = in_valid && in_ready;
  assign rx        = r_rx;
  assign ry        = r_ry;
  assign rz        = r_rz;
  assign out_sat   = r_sat;

  always_comb begin
    w_a = r_vx;
    w_b = r_vy;
    case (r_axis)
      2'd0:    begin w_a = r_vy; w_b = r_vz; end
      2'd1:    begin w_a = r_vz; w_b = r_vx; end
      default: begin w_a = r_vx; w_b = r_vy; end
    endcase
  end

  always_comb begin
    w_op_x = r_c;
    w_op_y = w_a;
    case (r_state)
      StM1:    begin w_op_x = r_s; w_op_y = w_b; end
      StM2:    begin w_op_x = r_s; w_op_y = w_a; end
      StM3:    begin w_op_x = r_c; w_op_y = w_b; end
      default: begin w_op_x = r_c; w_op_y = w_a; end
    endcase
  end

  assign w_prod  = AccW'(w_op_x) * AccW'(w_op_y);
  assign w_res_a = round_sat(r_acc_a);
  assign w_res_b = round_sat(r_acc_b);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_next = (axis == 2'd3) ? StRnd : StM0;
      StM0:    w_state_next = StM1;
      StM1:    w_state_next = StM2;
      StM2:    w_state_next = StM3;
      StM3:    w_state_next = StRnd;
      StRnd:   w_state_next = StOut;
      StOut:   if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_axis  <= '0;
      r_c     <= '0;
      r_s     <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_vz    <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_rz    <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_axis <= axis;
        r_c    <= cos_in;
        r_s    <= sin_in;
        r_vx   <= vx;
        r_vy   <= vy;
        r_vz   <= vz;
      end
      case (r_state)
        StM0: r_acc_a <= w_prod;
        StM1: r_acc_a <= r_acc_a - w_prod;
        StM2: r_acc_b <= w_prod;
        StM3: r_acc_b <= r_acc_b + w_prod;
        StRnd: begin
          // a' and b' go back into the slots their operands came from.
          case (r_axis)
            2'd0: begin
              r_rx <= r_vx; r_ry <= w_res_a[WIDTH-1:0]; r_rz <= w_res_b[WIDTH-1:0];
            end
            2'd1: begin
              r_rx <= w_res_b[WIDTH-1:0]; r_ry <= r_vy; r_rz <= w_res_a[WIDTH-1:0];
            end
            2'd2: begin
              r_rx <= w_res_a[WIDTH-1:0]; r_ry <= w_res_b[WIDTH-1:0]; r_rz <= r_vz;
            end
            default: begin
              r_rx <= r_vx; r_ry <= r_vy; r_rz <= r_vz;
            end
          endcase
          r_sat <= (r_axis != 2'd3) && (w_res_a[WIDTH] || w_res_b[WIDTH]);
        end
        default: ;
      endcase
    end
  end

endmodule
